// File: rtl/frogger_pkg.sv
// frogger_pkg: shared phase encoding and default game constants for the Frogger play controller
package frogger_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PLAY     = 3'd1,
        DYING    = 3'd2,
        GAMEOVER = 3'd3,
        WIN      = 3'd4
    } phase_t;

    localparam int FROG_LIVES     = 3;
    localparam int FROG_DIE_TICKS = 8;
    localparam int FROG_WIN_GOALS = 5;

endpackage

// File: rtl/tick_timer.sv
// tick_timer: 8-bit tick-enabled up counter with synchronous clear and terminal-count strobe
module tick_timer #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic done
);

    logic [7:0] count;

    // clear has priority so the counter restarts from zero on the cycle it is requested
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) count <= '0;
        else if (clear) count <= '0;
        else if (tick) count <= count + 8'd1;
    end

    assign done = tick && count == 8'(LIMIT - 1);

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: Frogger play-state controller owning phase, lives, score and frog respawn
module game_sequencer
    import frogger_pkg::*;
#(
    parameter int LIVES     = FROG_LIVES,
    parameter int DIE_TICKS = FROG_DIE_TICKS,
    parameter int WIN_GOALS = FROG_WIN_GOALS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       tick,
    input  logic       hit,
    input  logic       goal,
    output logic       run,
    output logic       frog_respawn,
    output logic       blink,
    output logic [3:0] lives_left,
    output logic [3:0] score,
    output logic [2:0] phase,
    output logic       game_over,
    output logic       win
);

    phase_t     state, state_nx;
    logic [3:0] lives_nx, score_nx, score_inc;
    logic       respawn_nx, run_nx, blink_nx, game_over_nx, win_nx;
    logic       dying, die_done;

    assign dying     = state == DYING;
    assign score_inc = score + 4'd1;
    assign phase     = state;

    // the death timer only advances inside DYING, so a tick in the entry cycle is never counted
    tick_timer #(.LIMIT(DIE_TICKS)) u_die_timer (
        .clk   (clk),
        .reset (reset),
        .clear (!dying || die_done),
        .tick  (tick && dying),
        .done  (die_done)
    );

    // state and every output are registered so they all move together one cycle after the cause
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            lives_left   <= 4'(LIVES);
            score        <= '0;
            frog_respawn <= 1'b0;
            run          <= 1'b0;
            blink        <= 1'b1;
            game_over    <= 1'b0;
            win          <= 1'b0;
        end else begin
            state        <= state_nx;
            lives_left   <= lives_nx;
            score        <= score_nx;
            frog_respawn <= respawn_nx;
            run          <= run_nx;
            blink        <= blink_nx;
            game_over    <= game_over_nx;
            win          <= win_nx;
        end
    end

    // phase transitions with the lives/score bookkeeping and respawn requests they cause
    always_comb begin
        state_nx   = state;
        lives_nx   = lives_left;
        score_nx   = score;
        respawn_nx = 1'b0;
        unique case (state)
            IDLE, GAMEOVER, WIN: begin
                if (start) begin
                    state_nx   = PLAY;
                    lives_nx   = 4'(LIVES);
                    score_nx   = '0;
                    respawn_nx = 1'b1;
                end
            end
            PLAY: begin
                if (hit) begin
                    state_nx = DYING;
                    lives_nx = lives_left - 4'd1;
                end else if (goal) begin
                    score_nx   = score_inc;
                    state_nx   = score_inc == 4'(WIN_GOALS) ? WIN : PLAY;
                    respawn_nx = score_inc != 4'(WIN_GOALS);
                end
            end
            DYING: begin
                if (die_done) begin
                    state_nx   = lives_left == 4'd0 ? GAMEOVER : PLAY;
                    respawn_nx = lives_left != 4'd0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // flags follow the upcoming phase; blink starts dark on DYING entry and flips on each counted tick
    always_comb begin
        run_nx       = state_nx == PLAY;
        game_over_nx = state_nx == GAMEOVER;
        win_nx       = state_nx == WIN;
        blink_nx     = state_nx != DYING ? 1'b1 : !dying ? 1'b0 : tick ? ~blink : blink;
    end

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed-vector bench for the Frogger play-state controller
module tb_game_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0, tick = 1'b0, hit = 1'b0, goal = 1'b0;
    logic       run, frog_respawn, blink, game_over, win;
    logic [3:0] lives_left, score;
    logic [2:0] phase;

    int nvec = 0;
    int nerr = 0;

    game_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .tick         (tick),
        .hit          (hit),
        .goal         (goal),
        .run          (run),
        .frog_respawn (frog_respawn),
        .blink        (blink),
        .lives_left   (lives_left),
        .score        (score),
        .phase        (phase),
        .game_over    (game_over),
        .win          (win)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // one death animation: hit, then DIE_TICKS ticks four cycles apart; checks lives after entry and blink per tick
    task automatic die(input logic [3:0] lives_exp);
        hit = 1'b1;
        @(negedge clk);
        hit = 1'b0;
        chk("die_phase", phase, 2);
        chk("die_lives", lives_left, lives_exp);
        chk("die_run", run, 0);
        chk("die_blink0", blink, 0);
        for (int k = 1; k <= 8; k++) begin
            idle(3);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            if (k < 8) begin
                chk("die_hold", phase, 2);
                chk("die_blink", blink, k % 2);
            end
        end
    endtask

    initial begin
        idle(3);
        chk("rst_in_phase", phase, 0);
        reset = 1'b1;
        idle(2);
        chk("rst_phase", phase, 0);
        chk("rst_run", run, 0);
        chk("rst_lives", lives_left, 3);
        chk("rst_score", score, 0);
        chk("rst_blink", blink, 1);
        chk("rst_gameover", game_over, 0);
        chk("rst_win", win, 0);
        chk("rst_respawn", frog_respawn, 0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_phase", phase, 1);
        chk("start_run", run, 1);
        chk("start_respawn", frog_respawn, 1);
        chk("start_lives", lives_left, 3);
        chk("start_score", score, 0);
        @(negedge clk);
        chk("start_respawn_end", frog_respawn, 0);

        die(4'd2);
        chk("d1_phase", phase, 1);
        chk("d1_respawn", frog_respawn, 1);
        chk("d1_blink", blink, 1);
        chk("d1_lives", lives_left, 2);
        @(negedge clk);
        chk("d1_respawn_end", frog_respawn, 0);

        die(4'd1);
        chk("d2_phase", phase, 1);
        die(4'd0);
        chk("d3_phase", phase, 3);
        chk("d3_gameover", game_over, 1);
        chk("d3_lives", lives_left, 0);
        chk("d3_respawn", frog_respawn, 0);
        chk("d3_blink", blink, 1);
        idle(2);
        chk("go_hold", phase, 3);

        start = 1'b1;
        tick = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tick = 1'b0;
        chk("restart_phase", phase, 1);
        chk("restart_lives", lives_left, 3);
        chk("restart_score", score, 0);
        chk("restart_gameover", game_over, 0);
        chk("restart_respawn", frog_respawn, 1);

        for (int g = 1; g <= 5; g++) begin
            idle(2);
            goal = 1'b1;
            @(negedge clk);
            goal = 1'b0;
            chk("goal_score", score, g);
            chk("goal_respawn", frog_respawn, g < 5);
            chk("goal_phase", phase, g < 5 ? 1 : 4);
        end
        chk("win_flag", win, 1);
        chk("win_run", run, 0);
        idle(2);
        chk("win_hold_score", score, 5);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("win_restart_phase", phase, 1);
        chk("win_restart_score", score, 0);
        chk("win_restart_win", win, 0);
        goal = 1'b1;
        @(negedge clk);
        goal = 1'b0;
        chk("pre_score", score, 1);

        hit = 1'b1;
        goal = 1'b1;
        tick = 1'b1;
        @(negedge clk);
        hit = 1'b0;
        goal = 1'b0;
        tick = 1'b0;
        chk("hg_phase", phase, 2);
        chk("hg_score", score, 1);
        chk("hg_lives", lives_left, 2);
        goal = 1'b1;
        start = 1'b1;
        @(negedge clk);
        goal = 1'b0;
        start = 1'b0;
        chk("dying_goal_ign", score, 1);
        chk("dying_start_ign", phase, 2);
        for (int k = 1; k <= 7; k++) begin
            idle(2);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
        chk("entry_tick_not_counted", phase, 2);
        chk("seven_blink", blink, 1);

        #2 reset = 1'b0;
        #1;
        chk("async_phase", phase, 0);
        chk("async_lives", lives_left, 3);
        chk("async_score", score, 0);
        chk("async_blink", blink, 1);
        chk("async_run", run, 0);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        chk("rst_tick_phase", phase, 0);
        reset = 1'b1;
        idle(2);
        chk("post_rst_phase", phase, 0);
        chk("post_rst_respawn", frog_respawn, 0);
        chk("post_rst_lives", lives_left, 3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level play-state controller for the Frogger LED-matrix game. It sequences the game through idle, play, death-animation, game-over and win phases, and owns the lives and score counters. It gates the lane movers, issues frog respawn pulses, and drives the end-of-game flags that select the game-over overlay pixel source.

## Interface

Parameters:
- LIVES, 3, lives per game; legal range 1..15.
- DIE_TICKS, 8, game ticks spent in the death animation; legal range 1..255.
- WIN_GOALS, 5, goals needed to win; legal range 1..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse from the debounced start button.
- tick  in  1  single-cycle game-tick strobe.
- hit  in  1  frog/car collision, sampled every cycle.
- goal  in  1  frog reached top row, sampled every cycle.
- run  out  1  enables lane movers and frog input.
- frog_respawn  out  1  one-cycle pulse that returns the frog to its start cell.
- blink  out  1  frog-layer visibility.
- lives_left  out  4  lives remaining.
- score  out  4  goals achieved this game.
- phase  out  3  encoded current state.
- game_over  out  1  high in GAMEOVER only.
- win  out  1  high in WIN only.

## Operation

- States: IDLE, PLAY, DYING, GAMEOVER, WIN.
- Entering PLAY from IDLE, GAMEOVER or WIN:
  - Triggered by start.
  - lives_left ← LIVES, score ← 0.
  - frog_respawn pulses.
- start in PLAY or DYING: ignored.
- PLAY, hit:
  - Go to DYING.
  - lives_left ← lives_left−1; death timer ← 0; blink ← 0.
- PLAY, goal with no hit:
  - score ← score+1.
  - If the new score equals WIN_GOALS, go to WIN.
  - Otherwise stay in PLAY and pulse frog_respawn.
- hit and goal in the same cycle: hit wins; score is unchanged.
- DYING:
  - hit and goal are ignored.
  - Each tick toggles blink and increments the timer.
  - On the tick where the timer equals DIE_TICKS−1:
    - If lives_left is 0, go to GAMEOVER.
    - Otherwise go to PLAY with a frog_respawn pulse (lives and score kept).
- Flags and outputs by state:
  - run = 1 only in PLAY.
  - blink = 1 in every state except DYING.
  - game_over = 1 only in GAMEOVER; win = 1 only in WIN.
  - lives_left and score hold their values in GAMEOVER and WIN.
- Arithmetic:
  - Counters never wrap. A decrement from 0 cannot occur, because leaving DYING with lives_left 0 ends the game.
  - The death timer is 8 bits.
- Reset values (reset low, asynchronous):
  - phase = IDLE.
  - run 0, frog_respawn 0, blink 1.
  - lives_left = LIVES, score 0.
  - game_over 0, win 0.
  - Timer 0.
- Reset asserted mid-game: immediate return to IDLE with the reset values above; no respawn pulse.

## Timing

- All outputs are registered and change on the rising clk edge after the causing input is sampled, so the latency is 1 cycle.
- frog_respawn is high for exactly the first cycle of each PLAY entry or goal-respawn, coincident with the updated score and lives.
- Death duration: DIE_TICKS ticks counted from the first tick after DYING entry. The tick in the entry cycle is not counted.
- tick is assumed to be at most 1 cycle wide. A tick arriving on the same cycle as hit is not counted.
- start and tick in the same cycle in GAMEOVER: start takes effect.
- Reset deassertion is synchronized externally; the first active edge after release evaluates IDLE.

## Structure

- Shared package frogger_pkg:
  - phase_t enum with fixed encodings: IDLE=0, PLAY=1, DYING=2, GAMEOVER=3, WIN=4.
  - Default constants FROG_LIVES, FROG_DIE_TICKS, FROG_WIN_GOALS.
  - The phase port is phase_t cast to 3 bits.
- One sub-module, tick_timer: an 8-bit tick-enabled up counter with synchronous clear and a terminal-count output (count==LIMIT−1 && tick). It implements the death timer.
- Next-state logic and output registers live in game_sequencer.

## Test plan

- Reset then release, no inputs:
  - phase 0, run 0, lives_left 3, score 0, blink 1, game_over 0, win 0.
- start pulse in IDLE:
  - Next cycle: phase 1, run 1, frog_respawn 1 for one cycle, lives_left 3, score 0.
- PLAY, hit, then 8 ticks spaced 4 cycles apart:
  - phase 2, lives_left 2, run 0.
  - blink toggles on each tick.
  - After the 8th tick: phase 1, frog_respawn pulse.
- Three hit/death cycles (LIVES=3):
  - After the third death animation: phase 3, game_over 1, lives_left 0.
  - Then a start pulse: phase 1, lives_left 3, score 0.
- Five goal pulses in PLAY (WIN_GOALS=5):
  - score 1..4, each with a frog_respawn pulse.
  - 5th goal: phase 4, win 1, score 5, no respawn.
  - Same-cycle hit+goal: DYING entered, score unchanged.
- Reset asserted low in DYING mid-animation:
  - Outputs return to reset values asynchronously.
  - A tick during reset has no effect.
